// File: rtl/actor_token_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : actor_port_pkg
//  Description : Shared widths and error-bit positions for actor port FIFOs.
//  Revision    : 1.0  initial release
// ============================================================================
package actor_port_pkg;

  localparam int TOKEN_W = 16;   // default token width
  localparam int COUNT_W = 16;   // width of the COUNT fields on both ports
  localparam int ERR_W   = 3;    // width of the sticky error vector

  // Bit positions inside ERR
  localparam int ERR_OVF = 0;    // write while full
  localparam int ERR_UNF = 1;    // pop while empty
  localparam int ERR_CNT = 2;    // write with COUNT != 1

endpackage : actor_port_pkg
`default_nettype wire

// File: rtl/actor_token_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : actor_token_fifo_if
//  Description : Producer-side and consumer-side port signals of one
//                actor-to-actor edge. The master drives stimulus (producer
//                data/strobes and consumer ACK); the slave is the FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
interface actor_token_fifo_if #(
  parameter int TOKEN_W = actor_port_pkg::TOKEN_W
);
  import actor_port_pkg::*;

  // Write side (producer -> FIFO)
  logic [TOKEN_W-1:0] W_DATA;
  logic               W_SEND;
  logic [COUNT_W-1:0] W_COUNT;
  logic               W_RDY;
  logic               W_ACK;

  // Read side (FIFO -> consumer)
  logic [TOKEN_W-1:0] R_DATA;
  logic               R_SEND;
  logic [COUNT_W-1:0] R_COUNT;
  logic               R_ACK;

  // Sticky error flags
  logic [ERR_W-1:0]   ERR;

  modport master (
    output W_DATA, W_SEND, W_COUNT, R_ACK,
    input  W_RDY, W_ACK, R_DATA, R_SEND, R_COUNT, ERR
  );

  modport slave (
    input  W_DATA, W_SEND, W_COUNT, R_ACK,
    output W_RDY, W_ACK, R_DATA, R_SEND, R_COUNT, ERR
  );

endinterface : actor_token_fifo_if
`default_nettype wire

// File: rtl/actor_token_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : actor_token_fifo_ram
//  Description : DEPTH x TOKEN_W token store. Synchronous write, asynchronous
//                read so the head token falls through without a cycle of
//                read latency. Contents are deliberately not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module actor_token_fifo_ram #(
  parameter int DEPTH   = 16,
  parameter int TOKEN_W = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  wire logic               CLK,
  input  wire logic               we,
  input  wire logic [ADDR_W-1:0]  wr_addr,
  input  wire logic [TOKEN_W-1:0] wr_data,
  input  wire logic [ADDR_W-1:0]  rd_addr,
  output logic      [TOKEN_W-1:0] rd_data
);

  logic [TOKEN_W-1:0] mem [DEPTH];

  // Store the accepted token at the write pointer
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : actor_token_fifo_ram
`default_nettype wire

// File: rtl/actor_token_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : actor_token_fifo
//  Description : Token FIFO on one actor-to-actor edge. Receives tokens with
//                the producer port handshake (SEND -> RDY/ACK) and offers
//                them first-word-fall-through with the consumer handshake
//                (SEND/COUNT -> ACK). Keeps sticky protocol error flags.
//  Revision    : 1.0  initial release
// ============================================================================
module actor_token_fifo #(
  parameter int DEPTH   = 16,
  parameter int TOKEN_W = actor_port_pkg::TOKEN_W
) (
  input  wire logic          CLK,
  input  wire logic          RESET,
  actor_token_fifo_if.slave  bus
);
  import actor_port_pkg::*;

  localparam int              ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] OCC_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] OCC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    occ;
  logic [ADDR_W:0]    occ_next;
  logic               w_rdy;
  logic               r_send;
  logic [COUNT_W-1:0] r_count;
  logic [ERR_W-1:0]   err;
  logic [ERR_W-1:0]   err_next;
  logic [TOKEN_W-1:0] head;
  logic               wr_en;
  logic               rd_en;

  // Handshakes qualify against registered flags only, so a full FIFO never
  // passes a write through a same-cycle pop and an empty FIFO never bypasses.
  assign wr_en = bus.W_SEND & w_rdy;
  assign rd_en = bus.R_ACK  & r_send;

  // Occupancy after this cycle's accepted write and pop
  always_comb begin
    occ_next = occ;
    unique case ({wr_en, rd_en})
      2'b10:   occ_next = occ + OCC_ONE;
      2'b01:   occ_next = occ - OCC_ONE;
      default: occ_next = occ;
    endcase
  end

  // Accumulate protocol violations into the sticky error vector
  always_comb begin
    err_next = err;
    if (bus.W_SEND && !w_rdy) begin
      err_next[ERR_OVF] = 1'b1;
    end
    if (bus.R_ACK && !r_send) begin
      err_next[ERR_UNF] = 1'b1;
    end
    if (bus.W_SEND && (bus.W_COUNT != COUNT_W'(1))) begin
      err_next[ERR_CNT] = 1'b1;
    end
  end

  // Pointers, occupancy and registered status flags; reset discards tokens
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      w_rdy   <= 1'b0;
      r_send  <= 1'b0;
      r_count <= '0;
      err     <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      occ     <= occ_next;
      w_rdy   <= (occ_next != OCC_FULL);
      r_send  <= (occ_next != '0);
      r_count <= COUNT_W'(occ_next);
      err     <= err_next;
    end
  end

  actor_token_fifo_ram #(
    .DEPTH   (DEPTH),
    .TOKEN_W (TOKEN_W),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.W_DATA),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // The RAM is not reset, so the head is masked while empty to keep
  // R_DATA at zero during and after reset.
  assign bus.R_DATA  = r_send ? head : '0;
  assign bus.R_SEND  = r_send;
  assign bus.R_COUNT = r_count;
  assign bus.W_RDY   = w_rdy;
  assign bus.W_ACK   = wr_en;
  assign bus.ERR     = err;

endmodule : actor_token_fifo
`default_nettype wire

// File: tb/tb_actor_token_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_actor_token_fifo
//  Description : Self-checking bench for actor_token_fifo with a token
//                scoreboard and per-scenario tasks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_actor_token_fifo;

  localparam int DEPTH = 16;

  logic CLK;
  logic RESET;

  actor_token_fifo_if #(.TOKEN_W(16)) bus ();

  actor_token_fifo #(.DEPTH(DEPTH), .TOKEN_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  int          m_occ  = 0;
  logic        m_rdy  = 1'b0;
  logic        m_send = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.W_SEND  = 1'b0;
    bus.W_DATA  = 16'h0000;
    bus.W_COUNT = 16'd0;
    bus.R_ACK   = 1'b0;
  endtask

  // One clock of stimulus; scoreboard checks W_ACK and popped tokens
  task automatic step(input logic send, input logic [15:0] data,
                      input logic [15:0] cnt, input logic ack);
    logic exp_ack;
    logic pop;
    bus.W_SEND  = send;
    bus.W_DATA  = data;
    bus.W_COUNT = cnt;
    bus.R_ACK   = ack;
    #1;
    exp_ack = send & m_rdy;
    pop     = ack & m_send;
    checks++;
    if (bus.W_ACK !== exp_ack) begin
      errors++;
      $display("FAIL w_ack: got %b required %b (data %h)", bus.W_ACK, exp_ack, data);
    end
    if (pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: pop with empty expectation queue, got %h", bus.R_DATA);
      end else begin
        if (bus.R_DATA !== exp_q[0]) begin
          errors++;
          $display("FAIL r_data order: got %h required %h", bus.R_DATA, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    if (exp_ack) exp_q.push_back(data);
    m_occ = m_occ + (exp_ack ? 1 : 0) - (pop ? 1 : 0);
    @(posedge CLK);
    #1;
    m_rdy  = (m_occ != DEPTH);
    m_send = (m_occ != 0);
    drive_idle();
  endtask

  task automatic apply_reset();
    drive_idle();
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_q.delete();
    m_occ  = 0;
    m_rdy  = 1'b0;
    m_send = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (bus.W_RDY !== 1'b0 || bus.R_SEND !== 1'b0 || bus.R_COUNT !== 16'd0 ||
        bus.ERR !== 3'b000 || bus.W_ACK !== 1'b0 || bus.R_DATA !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b send=%b cnt=%0d err=%b ack=%b data=%h required all zero",
               bus.W_RDY, bus.R_SEND, bus.R_COUNT, bus.ERR, bus.W_ACK, bus.R_DATA);
    end
    RESET = 1'b0;
    exp_q.delete();
    m_occ = 0; m_rdy = 1'b0; m_send = 1'b0;
    #2;
    checks++;
    if (bus.W_RDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_rdy: got %b required 0 before first edge", bus.W_RDY);
    end
    @(posedge CLK);
    #1;
    m_rdy = 1'b1;
    checks++;
    if (bus.W_RDY !== 1'b1 || bus.R_SEND !== 1'b0 || bus.R_COUNT !== 16'd0 || bus.ERR !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b send=%b cnt=%0d err=%b required rdy=1 send=0 cnt=0 err=000",
               bus.W_RDY, bus.R_SEND, bus.R_COUNT, bus.ERR);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 16'h0001, 16'd1, 1'b0);
    checks++;
    if (bus.R_SEND !== 1'b1 || bus.R_DATA !== 16'h0001) begin
      errors++;
      $display("FAIL b2b_latency: got send=%b data=%h required send=1 data=0001", bus.R_SEND, bus.R_DATA);
    end
    step(1'b1, 16'h0002, 16'd1, 1'b0);
    step(1'b1, 16'h0003, 16'd1, 1'b0);
    checks++;
    if (bus.R_COUNT !== 16'd3 || bus.R_DATA !== 16'h0001) begin
      errors++;
      $display("FAIL b2b_count: got cnt=%0d data=%h required cnt=3 data=0001", bus.R_COUNT, bus.R_DATA);
    end
    step(1'b0, 16'h0000, 16'd0, 1'b1);
    checks++;
    if (bus.R_DATA !== 16'h0002 || bus.R_COUNT !== 16'd2) begin
      errors++;
      $display("FAIL b2b_new_head: got data=%h cnt=%0d required data=0002 cnt=2", bus.R_DATA, bus.R_COUNT);
    end
    repeat (2) step(1'b0, 16'h0000, 16'd0, 1'b1);
    checks++;
    if (bus.R_SEND !== 1'b0 || bus.R_COUNT !== 16'd0) begin
      errors++;
      $display("FAIL b2b_drained: got send=%b cnt=%0d required send=0 cnt=0", bus.R_SEND, bus.R_COUNT);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h0100 + 16'(i), 16'd1, 1'b0);
    checks++;
    if (bus.W_RDY !== 1'b0 || bus.R_COUNT !== 16'd16) begin
      errors++;
      $display("FAIL full_flags: got rdy=%b cnt=%0d required rdy=0 cnt=16", bus.W_RDY, bus.R_COUNT);
    end
    // Write and pop together while full: write is dropped, pop proceeds
    step(1'b1, 16'hDEAD, 16'd1, 1'b1);
    checks++;
    if (bus.ERR !== 3'b001 || bus.R_COUNT !== 16'd15 || bus.W_RDY !== 1'b1) begin
      errors++;
      $display("FAIL full_overflow: got err=%b cnt=%0d rdy=%b required err=001 cnt=15 rdy=1",
               bus.ERR, bus.R_COUNT, bus.W_RDY);
    end
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 16'h0000, 16'd0, 1'b1);
    checks++;
    if (bus.R_COUNT !== 16'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_drain: got cnt=%0d pending=%0d required 0 and 0", bus.R_COUNT, exp_q.size());
    end
  endtask

  task automatic test_stream();
    int bad;
    bad = 0;
    step(1'b1, 16'h2000, 16'd1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 16'h2001 + 16'(i), 16'd1, 1'b1);
      if (bus.R_COUNT !== 16'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stream_occ: got %0d cycles with count != 1, required 0", bad);
    end
    step(1'b0, 16'h0000, 16'd0, 1'b1);
    checks++;
    if (bus.R_SEND !== 1'b0 || bus.R_COUNT !== 16'd0) begin
      errors++;
      $display("FAIL stream_end: got send=%b cnt=%0d required send=0 cnt=0", bus.R_SEND, bus.R_COUNT);
    end
  endtask

  task automatic test_errors();
    apply_reset();
    step(1'b0, 16'h0000, 16'd0, 1'b0);
    step(1'b0, 16'h0000, 16'd0, 1'b1);
    checks++;
    if (bus.ERR !== 3'b010 || bus.R_COUNT !== 16'd0) begin
      errors++;
      $display("FAIL underflow: got err=%b cnt=%0d required err=010 cnt=0", bus.ERR, bus.R_COUNT);
    end
    step(1'b1, 16'h3333, 16'd2, 1'b0);
    checks++;
    if (bus.ERR !== 3'b110 || bus.R_COUNT !== 16'd1) begin
      errors++;
      $display("FAIL count_err: got err=%b cnt=%0d required err=110 cnt=1", bus.ERR, bus.R_COUNT);
    end
    step(1'b0, 16'h0000, 16'd0, 1'b1);
    checks++;
    if (bus.R_COUNT !== 16'd0 || bus.R_SEND !== 1'b0) begin
      errors++;
      $display("FAIL count_err_once: got cnt=%0d send=%b required cnt=0 send=0", bus.R_COUNT, bus.R_SEND);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 9; i++) step(1'b1, 16'h5000 + 16'(i), 16'd1, 1'b0);
    checks++;
    if (bus.R_COUNT !== 16'd9) begin
      errors++;
      $display("FAIL mid_fill: got cnt=%0d required 9", bus.R_COUNT);
    end
    bus.W_SEND  = 1'b1;
    bus.W_DATA  = 16'h5999;
    bus.W_COUNT = 16'd1;
    bus.R_ACK   = 1'b1;
    #1;
    RESET = 1'b1;
    #1;
    checks++;
    if (bus.R_SEND !== 1'b0 || bus.R_COUNT !== 16'd0 || bus.W_RDY !== 1'b0 || bus.ERR !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got send=%b cnt=%0d rdy=%b err=%b required all zero",
               bus.R_SEND, bus.R_COUNT, bus.W_RDY, bus.ERR);
    end
    drive_idle();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_q.delete();
    m_occ = 0; m_rdy = 1'b0; m_send = 1'b0;
    step(1'b0, 16'h0000, 16'd0, 1'b0);
    step(1'b1, 16'h4444, 16'd1, 1'b0);
    checks++;
    if (bus.R_DATA !== 16'h4444 || bus.R_COUNT !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_head: got data=%h cnt=%0d required data=4444 cnt=1", bus.R_DATA, bus.R_COUNT);
    end
    step(1'b0, 16'h0000, 16'd0, 1'b1);
  endtask

  initial begin
    RESET = 1'b1;
    drive_idle();
    test_reset();
    test_back_to_back();
    test_full();
    test_stream();
    test_errors();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_actor_token_fifo
`default_nettype wire
